// File: rtl/frame_capture_ctrl.sv
// rtl/frame_capture_ctrl.sv - UART-commanded single-frame capture into RAM and byte-wise UART readout
//
// Ports:
//   clk, rst_n                      system clock, asynchronous active-low reset
//   rx_data, rx_ready               received UART byte and its one-cycle valid pulse
//   cam_frame_valid, cam_line_valid camera sync inputs (already in clk domain)
//   cam_data                        10-bit camera pixel; the 8 MSBs are stored
//   wr_en, wr_addr, wr_data         frame RAM write port (registered)
//   rd_addr, rd_data                frame RAM read port; rd_data lags rd_addr by one cycle
//   tx_data, tx_start, tx_busy      UART transmitter handshake
//   busy                            high whenever the sequencer is not idle
//   error                           sticky short-frame flag, cleared by the next accepted command

module frame_capture_ctrl #(
    parameter int          WIDTH       = 2,
    parameter int          HEIGHT      = 3,
    parameter int          ADDR_W      = 3,
    parameter logic [7:0]  CMD_CAPTURE = 8'h55
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    input  logic              cam_frame_valid,
    input  logic              cam_line_valid,
    input  logic [9:0]        cam_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic              busy,
    output logic              error
);

    localparam int COL_W = $clog2(WIDTH + 1);
    localparam int ROW_W = $clog2(HEIGHT + 1);
    localparam logic [COL_W-1:0]  COL_MAX   = COL_W'(WIDTH);
    localparam logic [ROW_W-1:0]  ROW_MAX   = ROW_W'(HEIGHT);
    localparam logic [ADDR_W:0]   PIX_TOTAL = (ADDR_W + 1)'(WIDTH * HEIGHT);
    localparam logic [ADDR_W:0]   PIX_LAST  = PIX_TOTAL - 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        SKIP,
        WAIT_FV,
        CAPTURE,
        RD_REQ,
        RD_LOAD,
        TX_PULSE,
        TX_WAIT
    } state_t;

    state_t           state;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [ADDR_W:0]  pix;
    logic [ADDR_W:0]  rd;
    logic [ADDR_W:0]  rd_inc;
    logic             lv_q;
    logic             tx_busy_q;
    logic             tx_first;

    assign rd_inc = rd + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            col       <= '0;
            row       <= '0;
            pix       <= '0;
            rd        <= '0;
            lv_q      <= 1'b0;
            tx_busy_q <= 1'b0;
            tx_first  <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            rd_addr   <= '0;
            tx_data   <= '0;
            tx_start  <= 1'b0;
            busy      <= 1'b0;
            error     <= 1'b0;
        end else begin
            wr_en     <= 1'b0;
            tx_start  <= 1'b0;
            lv_q      <= cam_line_valid;
            tx_busy_q <= tx_busy;

            case (state)
                IDLE: begin
                    if (rx_ready && rx_data == CMD_CAPTURE) begin
                        error <= 1'b0;
                        busy  <= 1'b1;
                        state <= SKIP;
                    end
                end

                // Never start mid-frame: wait for the current frame (if any) to end.
                SKIP: begin
                    if (!cam_frame_valid) state <= WAIT_FV;
                end

                WAIT_FV: begin
                    if (cam_frame_valid) begin
                        col   <= '0;
                        row   <= '0;
                        pix   <= '0;
                        state <= CAPTURE;
                    end
                end

                CAPTURE: begin
                    if (!cam_frame_valid) begin
                        // Frame end takes priority over any simultaneous line end.
                        if (pix == PIX_TOTAL) begin
                            rd      <= '0;
                            rd_addr <= '0;
                            state   <= RD_REQ;
                        end else begin
                            error <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else if (cam_line_valid) begin
                        if (col < COL_MAX && row < ROW_MAX) begin
                            wr_en   <= 1'b1;
                            wr_addr <= pix[ADDR_W-1:0];
                            wr_data <= cam_data[9:2];
                            pix     <= pix + 1'b1;
                        end
                        if (col < COL_MAX) col <= col + 1'b1;
                    end else if (lv_q) begin
                        if (row < ROW_MAX) row <= row + 1'b1;
                        col <= '0;
                    end
                end

                // rd_addr is already set on entry so the RAM's one-cycle read
                // latency lands the data in RD_LOAD.
                RD_REQ: begin
                    rd_addr <= rd[ADDR_W-1:0];
                    state   <= RD_LOAD;
                end

                RD_LOAD: begin
                    tx_data <= rd_data;
                    state   <= TX_PULSE;
                end

                TX_PULSE: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_first <= 1'b1;
                        state    <= TX_WAIT;
                    end
                end

                // The cycle right after the pulse is skipped so a transmitter
                // that raises busy one cycle late is not taken as finished.
                TX_WAIT: begin
                    if (tx_first) begin
                        tx_first <= 1'b0;
                    end else if (tx_busy_q && !tx_busy) begin
                        if (rd == PIX_LAST) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            rd      <= rd_inc;
                            rd_addr <= rd_inc[ADDR_W-1:0];
                            state   <= RD_REQ;
                        end
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// tb/tb_frame_capture_ctrl.sv - self-checking bench for frame_capture_ctrl

module tb_frame_capture_ctrl;

    localparam int W = 2;
    localparam int H = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       fv;
    logic       lv;
    logic [9:0] cam_data;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic [2:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       busy;
    logic       error;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    frame_capture_ctrl #(
        .WIDTH(W), .HEIGHT(H), .ADDR_W(3), .CMD_CAPTURE(8'h55)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_data(rx_data), .rx_ready(rx_ready),
        .cam_frame_valid(fv), .cam_line_valid(lv), .cam_data(cam_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .busy(busy), .error(error)
    );

    // Frame RAM: synchronous write, one-cycle read latency.
    logic [7:0] mem [0:7];
    always @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

    // Transmitter: busy rises tx_lag cycles after the pulse and stays tx_len cycles.
    int tx_len = 3;
    int tx_lag = 0;
    int pend;
    int cnt;
    bit active = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            active  = 1'b0;
            tx_busy = 1'b0;
        end else if (tx_start) begin
            active = 1'b1;
            pend   = tx_lag;
            cnt    = tx_len;
            if (pend == 0) tx_busy = 1'b1;
        end else if (active) begin
            if (pend > 0) begin
                pend = pend - 1;
                if (pend == 0) tx_busy = 1'b1;
            end else begin
                cnt = cnt - 1;
                if (cnt <= 0) begin
                    tx_busy = 1'b0;
                    active  = 1'b0;
                end
            end
        end
    end

    // Observed RAM writes and transmitted bytes.
    logic [15:0] wr_q [$];
    logic [7:0]  tx_q [$];
    logic [7:0]  exp_q [$];
    int          bad_start;
    always @(posedge clk) begin
        #1;
        if (wr_en) wr_q.push_back({5'b0, wr_addr, wr_data});
        if (tx_start) begin
            tx_q.push_back(tx_data);
            if (tx_busy) bad_start++;
        end
    end

    logic [9:0] cam_pix [0:3][0:2];

    // Reference: the first H lines, first W pixels each, raster order, 8 MSBs.
    function automatic bit model_frame(input int lines, input int ppl);
        exp_q.delete();
        for (int l = 0; l < lines && l < H; l++)
            for (int c = 0; c < ppl && c < W; c++)
                exp_q.push_back(cam_pix[l][c][9:2]);
        return (lines >= H) && (ppl >= W);
    endfunction

    task automatic clear_obs();
        wr_q.delete();
        tx_q.delete();
        bad_start = 0;
    endtask

    task automatic send_cmd(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic drive_frame(input int lines, input int ppl, input bit fixed, input bit fv_with_lv);
        for (int l = 0; l < 4; l++)
            for (int c = 0; c < 3; c++)
                cam_pix[l][c] = fixed ? 10'(((l + 1) * 10 + c + 1) * 4) : 10'($urandom);
        @(negedge clk);
        fv = 1'b1;
        repeat (2) @(negedge clk);
        for (int l = 0; l < lines; l++) begin
            for (int c = 0; c < ppl; c++) begin
                lv       = 1'b1;
                cam_data = cam_pix[l][c];
                @(negedge clk);
            end
            lv       = 1'b0;
            cam_data = 10'h0;
            if (fv_with_lv && l == lines - 1) fv = 1'b0;
            repeat (2) @(negedge clk);
        end
        fv = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_idle(input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx_data = 8'h00; rx_ready = 1'b0;
        fv = 1'b0; lv = 1'b0; cam_data = 10'h0; tx_busy = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({wr_en, tx_start, busy, error, wr_addr, wr_data, rd_addr, tx_data} !== 30'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {wr_en, tx_start, busy, error, wr_addr, wr_data, rd_addr, tx_data});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_nominal();
        bit ok, to;
        clear_obs();
        tx_len = 3; tx_lag = 0;
        // Frame already in progress when the command arrives.
        @(negedge clk); fv = 1'b1;
        repeat (2) @(negedge clk);
        for (int c = 0; c < 2; c++) begin lv = 1'b1; cam_data = 10'h3FF; @(negedge clk); end
        lv = 1'b0;
        @(negedge clk);
        send_cmd(8'h55);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL cmd_busy: got %b expected 1", busy); end
        for (int c = 0; c < 2; c++) begin lv = 1'b1; cam_data = 10'h3FC; @(negedge clk); end
        lv = 1'b0;
        repeat (2) @(negedge clk);
        fv = 1'b0;
        repeat (3) @(negedge clk);
        drive_frame(3, 2, 1'b1, 1'b0);
        ok = model_frame(3, 2);
        wait_idle(1000, to);
        checks++;
        if (to || !ok) begin errors++; $display("FAIL nom_done: timeout %b model_ok %b expected 0/1", to, ok); end
        checks++;
        if (wr_q.size() != 6) begin errors++; $display("FAIL nom_wr_count: got %0d expected 6", wr_q.size()); end
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            checks++;
            if (wr_q[i] !== {5'b0, 3'(i), exp_q[i]}) begin
                errors++; $display("FAIL nom_wr[%0d]: got %h expected %h", i, wr_q[i], {5'b0, 3'(i), exp_q[i]});
            end
        end
        checks++;
        if (tx_q.size() != 6) begin errors++; $display("FAIL nom_tx_count: got %0d expected 6", tx_q.size()); end
        for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++) begin
            checks++;
            if (tx_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL nom_tx[%0d]: got %h expected %h", i, tx_q[i], exp_q[i]);
            end
        end
        checks++;
        if (error !== 1'b0) begin errors++; $display("FAIL nom_error: got %b expected 0", error); end
    endtask

    task automatic test_wrong_cmd();
        clear_obs();
        send_cmd(8'hD5);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL badcmd_busy: got %b expected 0", busy); end
        drive_frame(3, 2, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        checks++;
        if (wr_q.size() != 0 || tx_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL badcmd_activity: writes %0d tx %0d busy %b expected 0 0 0", wr_q.size(), tx_q.size(), busy);
        end
    endtask

    task automatic test_short_frame();
        bit ok, to;
        clear_obs();
        send_cmd(8'h55);
        drive_frame(2, 2, 1'b0, 1'b0);
        ok = model_frame(2, 2);
        wait_idle(200, to);
        repeat (10) @(negedge clk);
        checks++;
        if (to || error !== !ok) begin errors++; $display("FAIL short_error: got %b (timeout %b) expected %b", error, to, !ok); end
        checks++;
        if (tx_q.size() != 0) begin errors++; $display("FAIL short_tx: got %0d starts expected 0", tx_q.size()); end
        checks++;
        if (wr_q.size() != exp_q.size()) begin errors++; $display("FAIL short_wr_count: got %0d expected %0d", wr_q.size(), exp_q.size()); end
        send_cmd(8'h55);
        checks++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL short_clear: error %b busy %b expected 0 1", error, busy);
        end
        clear_obs();
        drive_frame(3, 2, 1'b0, 1'b0);
        ok = model_frame(3, 2);
        wait_idle(1000, to);
        checks++;
        if (to || tx_q.size() != 6) begin errors++; $display("FAIL short_recover: tx %0d timeout %b expected 6 0", tx_q.size(), to); end
    endtask

    task automatic test_oversized();
        bit ok, to;
        clear_obs();
        tx_len = 2; tx_lag = 1;
        send_cmd(8'h55);
        drive_frame(4, 3, 1'b0, 1'b0);
        ok = model_frame(4, 3);
        wait_idle(1000, to);
        checks++;
        if (to || wr_q.size() != exp_q.size()) begin
            errors++; $display("FAIL over_wr_count: got %0d (timeout %b) expected %0d", wr_q.size(), to, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            checks++;
            if (wr_q[i] !== {5'b0, 3'(i), exp_q[i]}) begin
                errors++; $display("FAIL over_wr[%0d]: got %h expected %h", i, wr_q[i], {5'b0, 3'(i), exp_q[i]});
            end
        end
        checks++;
        if (tx_q.size() != exp_q.size()) begin errors++; $display("FAIL over_tx_count: got %0d expected %0d", tx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++) begin
            checks++;
            if (tx_q[i] !== exp_q[i]) begin errors++; $display("FAIL over_tx[%0d]: got %h expected %h", i, tx_q[i], exp_q[i]); end
        end
        checks++;
        if (error !== (ok ? 1'b0 : 1'b1)) begin errors++; $display("FAIL over_error: got %b expected %b", error, !ok); end
    endtask

    task automatic test_slow_tx();
        bit ok, to;
        clear_obs();
        tx_len = 40; tx_lag = 1;
        send_cmd(8'h55);
        drive_frame(3, 2, 1'b0, 1'b0);
        ok = model_frame(3, 2);
        wait_idle(2000, to);
        checks++;
        if (to || tx_q.size() != 6) begin errors++; $display("FAIL slow_tx_count: got %0d (timeout %b) expected 6", tx_q.size(), to); end
        for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++) begin
            checks++;
            if (tx_q[i] !== exp_q[i]) begin errors++; $display("FAIL slow_tx[%0d]: got %h expected %h", i, tx_q[i], exp_q[i]); end
        end
        checks++;
        if (bad_start != 0) begin errors++; $display("FAIL slow_start_while_busy: got %0d expected 0", bad_start); end
    endtask

    task automatic test_reset_abort();
        bit ok, to;
        int n_wr, n_tx;
        clear_obs();
        tx_len = 40; tx_lag = 0;
        send_cmd(8'h55);
        fork
            drive_frame(3, 2, 1'b0, 1'b0);
            begin
                repeat (7) @(negedge clk);
                #2 rst_n = 1'b0;
                #1;
                checks++;
                if ({wr_en, tx_start, busy, error, wr_addr, wr_data, rd_addr, tx_data} !== 30'h0) begin
                    errors++;
                    $display("FAIL rst_capture_outputs: got %h expected 0",
                             {wr_en, tx_start, busy, error, wr_addr, wr_data, rd_addr, tx_data});
                end
                n_wr = wr_q.size();
            end
        join
        repeat (3) @(negedge clk);
        checks++;
        if (wr_q.size() != n_wr) begin errors++; $display("FAIL rst_capture_writes: got %0d expected %0d", wr_q.size(), n_wr); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        send_cmd(8'h55);
        drive_frame(3, 2, 1'b0, 1'b0);
        to = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (tx_q.size() >= 2) begin to = 1'b0; break; end
        end
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (to || {wr_en, tx_start, busy, error, wr_addr, wr_data, rd_addr, tx_data} !== 30'h0) begin
            errors++;
            $display("FAIL rst_tx_outputs: got %h (timeout %b) expected 0",
                     {wr_en, tx_start, busy, error, wr_addr, wr_data, rd_addr, tx_data}, to);
        end
        n_tx = tx_q.size();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        checks++;
        if (tx_q.size() != n_tx || busy !== 1'b0) begin
            errors++; $display("FAIL rst_tx_quiet: starts %0d busy %b expected %0d 0", tx_q.size(), busy, n_tx);
        end

        clear_obs();
        tx_len = 4; tx_lag = 0;
        send_cmd(8'h55);
        drive_frame(3, 2, 1'b0, 1'b0);
        ok = model_frame(3, 2);
        wait_idle(1000, to);
        checks++;
        if (to || wr_q.size() != 6 || tx_q.size() != 6) begin
            errors++; $display("FAIL rst_recover_count: writes %0d tx %0d timeout %b expected 6 6 0", wr_q.size(), tx_q.size(), to);
        end
        for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++) begin
            checks++;
            if (tx_q[i] !== exp_q[i]) begin errors++; $display("FAIL rst_recover_tx[%0d]: got %h expected %h", i, tx_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        bit ok, to, fvl;
        int lines, ppl;
        for (int it = 0; it < 5; it++) begin
            clear_obs();
            lines  = (it == 0) ? 3 : int'($urandom_range(1, 4));
            ppl    = (it == 0) ? 2 : int'($urandom_range(1, 3));
            fvl    = (it == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            tx_len = $urandom_range(1, 8);
            tx_lag = $urandom_range(0, 1);
            send_cmd(8'h55);
            drive_frame(lines, ppl, 1'b0, fvl);
            ok = model_frame(lines, ppl);
            wait_idle(1000, to);
            checks++;
            if (to || error !== !ok) begin
                errors++; $display("FAIL b2b%0d_error: got %b (timeout %b) expected %b", it, error, to, !ok);
            end
            checks++;
            if (wr_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b%0d_wr_count: got %0d expected %0d", it, wr_q.size(), exp_q.size()); end
            checks++;
            if (tx_q.size() != (ok ? exp_q.size() : 0)) begin
                errors++; $display("FAIL b2b%0d_tx_count: got %0d expected %0d", it, tx_q.size(), ok ? exp_q.size() : 0);
            end
            for (int i = 0; i < tx_q.size() && i < exp_q.size(); i++) begin
                checks++;
                if (tx_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b%0d_tx[%0d]: got %h expected %h", it, i, tx_q[i], exp_q[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_wrong_cmd();
        test_short_frame();
        test_oversized();
        test_slow_tx();
        test_reset_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
